// File: rtl/game_pkg.sv
// Shared geometry, lane constants and FSM state encoding for the road-crossing game.
// vga_control imports the same package so sprite compares use identical geometry.
package game_pkg;
  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;
  localparam int PLAYER_W   = 32;
  localparam int PLAYER_H   = 32;
  localparam int CAR_W      = 64;
  localparam int CAR_H      = 32;
  localparam int STEP       = 32;
  localparam int START_X    = 304;
  localparam int START_Y    = 448;
  localparam int LANE_Y0    = 96;
  localparam int LANE_PITCH = 64;
  localparam int LIVES_INIT = 3;
  localparam int NUM_LANES  = 4;
  localparam int NUM_BTNS   = 4;

  localparam logic [3:0] SPEED     [NUM_LANES] = '{4'd2, 4'd3, 4'd4, 4'd5};
  localparam logic [9:0] CAR_RST_X [NUM_LANES] = '{10'd0, 10'd160, 10'd320, 10'd480};

  typedef enum logic [2:0] {IDLE, MOVE, CARS, HIT, RESOLVE, OVER} state_e;

  function automatic logic [9:0] lane_y(input logic [1:0] n, input int y0, input int pitch);
    return 10'(y0 + pitch * int'(n));
  endfunction
endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detect on the button levels with sticky pending flags.
// A new edge in the same cycle as a clear survives the clear.
module btn_edge_latch
  import game_pkg::*;
#(
  parameter int W = NUM_BTNS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] btn_i,
  input  logic         clr_i,
  output logic [W-1:0] pend_o
);
  logic [W-1:0] prev_q, pend_q, pend_d, rise;

  assign rise   = btn_i & ~prev_q;
  assign pend_d = rise | (clr_i ? '0 : pend_q);
  assign pend_o = pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= btn_i;
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/frame_update_scheduler.sv
// Once-per-frame game-state sequencer: move, advance cars, collide, resolve.
// All position outputs change only during vertical blanking.
module frame_update_scheduler
  import game_pkg::*;
#(
  parameter int H_DISPLAY  = game_pkg::H_DISPLAY,
  parameter int V_DISPLAY  = game_pkg::V_DISPLAY,
  parameter int PLAYER_W   = game_pkg::PLAYER_W,
  parameter int PLAYER_H   = game_pkg::PLAYER_H,
  parameter int CAR_W      = game_pkg::CAR_W,
  parameter int CAR_H      = game_pkg::CAR_H,
  parameter int STEP       = game_pkg::STEP,
  parameter int START_X    = game_pkg::START_X,
  parameter int START_Y    = game_pkg::START_Y,
  parameter int LANE_Y0    = game_pkg::LANE_Y0,
  parameter int LANE_PITCH = game_pkg::LANE_PITCH,
  parameter int SPEED0     = int'(SPEED[0]),
  parameter int SPEED1     = int'(SPEED[1]),
  parameter int SPEED2     = int'(SPEED[2]),
  parameter int SPEED3     = int'(SPEED[3]),
  parameter int LIVES_INIT = game_pkg::LIVES_INIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [9:0] car_x0,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic       win_pulse
);
  state_e     state_q;
  logic [1:0] idx_q;
  logic       hit_q;
  logic [9:0] px_q, py_q;
  logic [9:0] car_q [NUM_LANES];
  logic [1:0] lives_q;
  logic [7:0] score_q;
  logic       go_q, win_q;

  logic       tick, clr;
  logic [3:0] pend;
  logic [3:0] speed;
  logic [9:0] cur_x, cy;
  logic [10:0] spd, add_a, add_b, add_sum, px11, py11, cy11, cx11;
  logic       overlap;

  assign tick = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
  assign clr  = (state_q == MOVE) || ((state_q == OVER) && tick && (|pend));

  btn_edge_latch #(.W(NUM_BTNS)) u_btn (
    .clk_i  (CLK),
    .rst_i  (RST),
    .btn_i  ({BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP}),
    .clr_i  (clr),
    .pend_o (pend)
  );

  always_comb begin
    case (idx_q)
      2'd0:    speed = 4'(SPEED0);
      2'd1:    speed = 4'(SPEED1);
      2'd2:    speed = 4'(SPEED2);
      default: speed = 4'(SPEED3);
    endcase
  end

  assign cur_x = car_q[idx_q];
  assign spd   = {7'd0, speed};
  assign cx11  = {1'b0, cur_x};

  // Single adder: wrap is folded into the operand so each lane needs one add.
  // In HIT the same adder forms the car's right edge.
  always_comb begin
    add_a = cx11;
    add_b = 11'(CAR_W);
    if (state_q == CARS) begin
      if (!idx_q[0])
        add_b = (cx11 >= 11'(H_DISPLAY) - spd) ? spd - 11'(H_DISPLAY) : spd;
      else
        add_b = (cx11 < spd) ? 11'(H_DISPLAY) - spd : 11'd0 - spd;
    end
  end
  assign add_sum = add_a + add_b;

  assign cy      = lane_y(idx_q, LANE_Y0, LANE_PITCH);
  assign cy11    = {1'b0, cy};
  assign px11    = {1'b0, px_q};
  assign py11    = {1'b0, py_q};
  assign overlap = (px11 < add_sum) && (cx11 < px11 + 11'(PLAYER_W)) &&
                   (py11 < cy11 + 11'(CAR_H)) && (cy11 < py11 + 11'(PLAYER_H));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hit_q   <= 1'b0;
      px_q    <= 10'(START_X);
      py_q    <= 10'(START_Y);
      for (int i = 0; i < NUM_LANES; i++) car_q[i] <= CAR_RST_X[i];
      lives_q <= 2'(LIVES_INIT);
      score_q <= 8'd0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      win_q <= 1'b0;
      case (state_q)
        IDLE: if (tick) begin
          if (lives_q == 2'd0) begin
            state_q <= OVER;
            go_q    <= 1'b1;
          end else begin
            state_q <= MOVE;
          end
        end
        MOVE: begin
          if (pend[0]) begin
            if (py_q >= 10'(STEP)) py_q <= py_q - 10'(STEP);
          end else if (pend[1]) begin
            if (py11 + 11'(STEP) <= 11'(V_DISPLAY - PLAYER_H)) py_q <= py_q + 10'(STEP);
          end else if (pend[2]) begin
            if (px_q >= 10'(STEP)) px_q <= px_q - 10'(STEP);
          end else if (pend[3]) begin
            if (px11 + 11'(STEP) <= 11'(H_DISPLAY - PLAYER_W)) px_q <= px_q + 10'(STEP);
          end
          idx_q   <= 2'd0;
          state_q <= CARS;
        end
        CARS: begin
          car_q[idx_q] <= add_sum[9:0];
          idx_q        <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= HIT;
        end
        HIT: begin
          if (overlap) hit_q <= 1'b1;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= RESOLVE;
        end
        RESOLVE: begin
          if (hit_q) begin
            lives_q <= lives_q - 2'd1;
            px_q    <= 10'(START_X);
            py_q    <= 10'(START_Y);
          end else if (py_q == 10'd0) begin
            score_q <= score_q + 8'd1;
            win_q   <= 1'b1;
            px_q    <= 10'(START_X);
            py_q    <= 10'(START_Y);
          end
          hit_q   <= 1'b0;
          state_q <= IDLE;
        end
        OVER: if (tick && (|pend)) begin
          lives_q <= 2'(LIVES_INIT);
          score_q <= 8'd0;
          px_q    <= 10'(START_X);
          py_q    <= 10'(START_Y);
          for (int i = 0; i < NUM_LANES; i++) car_q[i] <= CAR_RST_X[i];
          go_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign player_x  = px_q;
  assign player_y  = py_q;
  assign car_x0    = car_q[0];
  assign car_x1    = car_q[1];
  assign car_x2    = car_q[2];
  assign car_x3    = car_q[3];
  assign lives     = lives_q;
  assign score     = score_q;
  assign game_over = go_q;
  assign win_pulse = win_q;
endmodule
